menu_page_gen: RTL and testbench



---
 rtl/menu_page_gen.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_menu_page_gen.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_page_gen.sv
// ---------------------------------------------------------------------------
// menu_page_gen
//
// Menu page for the 320x240 VGA path. It draws N_ITEMS option rows. Each row
// shows one of N_VALS label sprites, and blinking arrows surround the cursor
// row. The block also owns the cursor and per-item value registers, which are
// driven by pre-debounced button pulses. When the player confirms, it emits a
// one-cycle start pulse.
//
// Build option:
//   MENU_LOCK_DIM_EN - when defined, labels are drawn at half intensity while
//                      LOCKED. Arrows are hidden in LOCKED in either build.
//
// Ports:
//   clk_25MHz, rst          pixel clock, synchronous active-high reset
//   btn_up/down/left/right  single-cycle button pulses (menu navigation)
//   btn_enter               single-cycle pulse: lock + start / unlock
//   h_cnt, v_cnt            current pixel coordinate (pipeline stage 0)
//   label_addr, label_bit   label ROM address out, data back one cycle later
//   arrow_addr, arrow_bit   arrow ROM address out, data back one cycle later
//   pixel                   RGB444, two cycles after h_cnt/v_cnt
//   cursor, item_val        current row, packed values (item i at [2i+1:2i])
//   locked, start           LOCKED state flag, one-cycle confirm pulse
//   dbg_state, dbg_blink    FSM state and blink counter, for observation
//
// Button pulses have no handshake. Each pulse is acted on in the cycle it is
// high, and its effect shows on the registered outputs on the next cycle.
// ---------------------------------------------------------------------------
module menu_page_gen #(
    parameter int          N_ITEMS    = 3,
    parameter int          N_VALS     = 3,
    parameter int          H_CENTER   = 160,
    parameter int          V_TOP      = 138,
    parameter int          ROW_PITCH  = 21,
    parameter int          LABEL_W    = 38,
    parameter int          LABEL_H    = 12,
    parameter int          ARROW_GAP  = 4,
    parameter logic [11:0] SEL_COLOR  = 12'hFF0,
    parameter int          BLINK_BITS = 23
) (
    input  logic                    clk_25MHz,
    input  logic                    rst,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    btn_enter,
    input  logic [8:0]              h_cnt,
    input  logic [8:0]              v_cnt,
    output logic [16:0]             label_addr,
    input  logic                    label_bit,
    output logic [4:0]              arrow_addr,
    input  logic                    arrow_bit,
    output logic [11:0]             pixel,
    output logic [1:0]              cursor,
    output logic [2*N_ITEMS-1:0]    item_val,
    output logic                    locked,
    output logic                    start,
    output logic                    dbg_state,
    output logic [BLINK_BITS-1:0]   dbg_blink
);

    typedef enum logic {
        ST_MENU   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [1:0]            LAST_ROW  = 2'(N_ITEMS - 1);
    localparam logic [1:0]            LAST_VAL  = 2'(N_VALS - 1);
    localparam logic [BLINK_BITS-1:0] BLINK_ONE = 1;

    // Screen geometry, all in 17-bit unsigned arithmetic.
    localparam logic [16:0] LBL_X0   = 17'(H_CENTER - LABEL_W / 2);
    localparam logic [16:0] LBL_X1   = 17'(H_CENTER + LABEL_W / 2);
    localparam logic [16:0] LARR_X0  = 17'(H_CENTER - LABEL_W / 2 - ARROW_GAP - 4);
    localparam logic [16:0] RARR_X0  = 17'(H_CENTER + LABEL_W / 2 + ARROW_GAP);
    localparam logic [16:0] ARR_DY   = 17'((LABEL_H - 6) / 2);
    localparam logic [16:0] LW       = 17'(LABEL_W);
    localparam logic [16:0] LH       = 17'(LABEL_H);
    localparam logic [16:0] LBL_SIZE = 17'(LABEL_W * LABEL_H);

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_edit_en;
    logic                    w_start_next;

    logic [1:0]              r_cursor;
    logic [1:0]              w_cursor_next;
    logic [1:0]              r_val      [N_ITEMS];
    logic [1:0]              w_val_next [N_ITEMS];
    logic                    r_start;
    logic [BLINK_BITS-1:0]   r_blink;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_state <= ST_MENU;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state. Enter toggles between MENU and LOCKED.
    always_comb begin
        w_state_next = r_state;
        if (btn_enter) begin
            w_state_next = (r_state == ST_MENU) ? ST_LOCKED : ST_MENU;
        end
    end

    // FSM: outputs. Enter takes priority over navigation in the same cycle.
    always_comb begin
        locked       = (r_state == ST_LOCKED);
        dbg_state    = r_state;
        w_edit_en    = (r_state == ST_MENU) && !btn_enter;
        w_start_next = (r_state == ST_MENU) && btn_enter;
    end

    // ------------------------------------------------------------------
    // Cursor and value edits. Value edits target the row under the cursor
    // before this cycle's vertical move. Opposing pulses cancel each other.
    // ------------------------------------------------------------------
    always_comb begin
        w_cursor_next = r_cursor;
        for (int i = 0; i < N_ITEMS; i++) begin
            w_val_next[i] = r_val[i];
        end
        if (w_edit_en) begin
            if (btn_up && !btn_down) begin
                w_cursor_next = (r_cursor == 2'd0) ? LAST_ROW : r_cursor - 2'd1;
            end else if (btn_down && !btn_up) begin
                w_cursor_next = (r_cursor == LAST_ROW) ? 2'd0 : r_cursor + 2'd1;
            end
            for (int i = 0; i < N_ITEMS; i++) begin
                if (r_cursor == 2'(i)) begin
                    if (btn_right && !btn_left) begin
                        w_val_next[i] = (r_val[i] == LAST_VAL) ? 2'd0 : r_val[i] + 2'd1;
                    end else if (btn_left && !btn_right) begin
                        w_val_next[i] = (r_val[i] == 2'd0) ? LAST_VAL : r_val[i] - 2'd1;
                    end
                end
            end
        end
    end

    // The blink counter restarts on every cursor move, so the arrows show
    // up at once at the new row.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_cursor <= 2'd0;
            r_start  <= 1'b0;
            r_blink  <= '0;
            for (int i = 0; i < N_ITEMS; i++) begin
                r_val[i] <= 2'd0;
            end
        end else begin
            r_cursor <= w_cursor_next;
            r_start  <= w_start_next;
            r_blink  <= (w_cursor_next != r_cursor) ? '0 : r_blink + BLINK_ONE;
            for (int i = 0; i < N_ITEMS; i++) begin
                r_val[i] <= w_val_next[i];
            end
        end
    end

    always_comb begin
        item_val = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            item_val[2*i +: 2] = r_val[i];
        end
    end

    assign cursor    = r_cursor;
    assign start     = r_start;
    assign dbg_blink = r_blink;

    // ------------------------------------------------------------------
    // Stage 0: region decode and ROM addressing. Regions never overlap, so
    // the first row that matches wins.
    // ------------------------------------------------------------------
    logic [16:0] w_h;
    logic [16:0] w_v;
    logic [16:0] w_top;
    logic [16:0] w_dx;
    logic [16:0] w_dy;
    logic        w_found;
    logic        w_in_label;
    logic        w_in_arrow;
    logic [1:0]  w_row;
    logic [16:0] w_label_addr;
    logic [4:0]  w_arrow_addr;

    assign w_h = {8'd0, h_cnt};
    assign w_v = {8'd0, v_cnt};

    always_comb begin
        w_top        = '0;
        w_dx         = '0;
        w_dy         = '0;
        w_found      = 1'b0;
        w_in_label   = 1'b0;
        w_in_arrow   = 1'b0;
        w_row        = 2'd0;
        w_label_addr = '0;
        w_arrow_addr = '0;
        for (int r = 0; r < N_ITEMS; r++) begin
            w_top = 17'(V_TOP + r * ROW_PITCH);
            if (!w_found && w_v >= w_top && w_v < w_top + LH &&
                w_h >= LBL_X0 && w_h < LBL_X1) begin
                w_found      = 1'b1;
                w_in_label   = 1'b1;
                w_row        = 2'(r);
                w_dx         = w_h - LBL_X0;
                w_dy         = w_v - w_top;
                w_label_addr = (17'(r * N_VALS) + {15'd0, r_val[r]}) * LBL_SIZE
                               + w_dx + w_dy * LW;
            end else if (!w_found && w_v >= w_top + ARR_DY &&
                         w_v < w_top + ARR_DY + 17'd6) begin
                w_dy = w_v - w_top - ARR_DY;
                if (w_h >= LARR_X0 && w_h < LARR_X0 + 17'd4) begin
                    w_found      = 1'b1;
                    w_in_arrow   = 1'b1;
                    w_row        = 2'(r);
                    w_dx         = w_h - LARR_X0;
                    w_arrow_addr = 5'(w_dx) + {w_dy[2:0], 2'b00};
                end else if (w_h >= RARR_X0 && w_h < RARR_X0 + 17'd4) begin
                    // The right arrow reuses the left sprite, mirrored.
                    w_found      = 1'b1;
                    w_in_arrow   = 1'b1;
                    w_row        = 2'(r);
                    w_dx         = w_h - RARR_X0;
                    w_arrow_addr = (5'd3 - 5'(w_dx)) + {w_dy[2:0], 2'b00};
                end
            end
        end
    end

    assign label_addr = rst ? 17'd0 : w_label_addr;
    assign arrow_addr = rst ? 5'd0  : w_arrow_addr;

    // ------------------------------------------------------------------
    // Stage 1: region flags, registered so they line up with ROM data.
    // ------------------------------------------------------------------
    logic r_s1_label;
    logic r_s1_arrow;
    logic r_s1_cursor;
    logic r_s1_arrow_vis;
`ifdef MENU_LOCK_DIM_EN
    logic r_s1_locked;
`endif

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_s1_label     <= 1'b0;
            r_s1_arrow     <= 1'b0;
            r_s1_cursor    <= 1'b0;
            r_s1_arrow_vis <= 1'b0;
`ifdef MENU_LOCK_DIM_EN
            r_s1_locked    <= 1'b0;
`endif
        end else begin
            r_s1_label     <= w_in_label;
            r_s1_arrow     <= w_in_arrow;
            r_s1_cursor    <= (w_row == r_cursor);
            r_s1_arrow_vis <= (r_state == ST_MENU) && !r_blink[BLINK_BITS-1];
`ifdef MENU_LOCK_DIM_EN
            r_s1_locked    <= (r_state == ST_LOCKED);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: pixel colour. Labels take precedence over arrows.
    // ------------------------------------------------------------------
    logic [11:0] w_label_color;
    logic [11:0] w_pixel_next;
    logic [11:0] r_pixel;

    always_comb begin
        w_label_color = r_s1_cursor ? SEL_COLOR : 12'hFFF;
        w_pixel_next  = 12'h000;
        if (r_s1_label && label_bit) begin
`ifdef MENU_LOCK_DIM_EN
            w_pixel_next = r_s1_locked ? ((w_label_color >> 1) & 12'h777) : w_label_color;
`else
            w_pixel_next = w_label_color;
`endif
        end else if (r_s1_arrow && r_s1_cursor && r_s1_arrow_vis && arrow_bit) begin
            w_pixel_next = SEL_COLOR;
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_pixel <= 12'h000;
        end else begin
            r_pixel <= w_pixel_next;
        end
    end

    assign pixel = r_pixel;

endmodule

// File: tb/tb_menu_page_gen.sv
// ---------------------------------------------------------------------------
// tb_menu_page_gen
//
// Bench for menu_page_gen. The DUT is built with a short blink counter so the
// blink period fits in a short run. Button effects are predicted by a
// behavioural model and queued in exp_q. Expected pixels are queued in pix_q
// when a coordinate is driven, and popped once the two-cycle pipeline
// delivers the result.
// ---------------------------------------------------------------------------
module tb_menu_page_gen;

    localparam int BB = 6;

    logic          clk_25MHz = 1'b0;
    logic          rst       = 1'b1;
    logic          btn_up    = 1'b0;
    logic          btn_down  = 1'b0;
    logic          btn_left  = 1'b0;
    logic          btn_right = 1'b0;
    logic          btn_enter = 1'b0;
    logic [8:0]    h_cnt     = 9'd0;
    logic [8:0]    v_cnt     = 9'd0;
    logic [16:0]   label_addr;
    logic          label_bit = 1'b0;
    logic [4:0]    arrow_addr;
    logic          arrow_bit = 1'b0;
    logic [11:0]   pixel;
    logic [1:0]    cursor;
    logic [5:0]    item_val;
    logic          locked;
    logic          start;
    logic          dbg_state;
    logic [BB-1:0] dbg_blink;

    menu_page_gen #(.BLINK_BITS(BB)) dut (
        .clk_25MHz (clk_25MHz),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_enter (btn_enter),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .label_addr(label_addr),
        .label_bit (label_bit),
        .arrow_addr(arrow_addr),
        .arrow_bit (arrow_bit),
        .pixel     (pixel),
        .cursor    (cursor),
        .item_val  (item_val),
        .locked    (locked),
        .start     (start),
        .dbg_state (dbg_state),
        .dbg_blink (dbg_blink)
    );

    // ---------------- clock ----------------
    always #20 clk_25MHz = ~clk_25MHz;

    // ---------------- scoreboard ----------------
    int          n_pass  = 0;
    int          n_total = 0;
    logic [9:0]  exp_q[$];   // {start, locked, cursor, item_val}
    logic [11:0] pix_q[$];

    // Model of the menu control state.
    int m_cursor;
    int m_val[3];
    bit m_locked;

    typedef struct {
        int          h;
        int          v;
        logic        lb;
        logic        ab;
        logic [16:0] la;
        logic [4:0]  aa;
        logic [11:0] px;
    } pt_t;

    task automatic model_reset();
        m_cursor = 0;
        m_val[0] = 0;
        m_val[1] = 0;
        m_val[2] = 0;
        m_locked = 0;
    endtask

    // Driver: b = {enter, right, left, down, up}. This task pushes the
    // expected outcome, drives the pulse for one cycle and returns at the
    // next negedge.
    task automatic press(input logic [4:0] b);
        logic st;
        int   c0;
        st = 1'b0;
        c0 = m_cursor;
        if (!m_locked) begin
            if (b[4]) begin
                st       = 1'b1;
                m_locked = 1'b1;
            end else begin
                if (b[0] && !b[1])      m_cursor = (m_cursor == 0) ? 2 : m_cursor - 1;
                else if (b[1] && !b[0]) m_cursor = (m_cursor == 2) ? 0 : m_cursor + 1;
                if (b[3] && !b[2])      m_val[c0] = (m_val[c0] + 1) % 3;
                else if (b[2] && !b[3]) m_val[c0] = (m_val[c0] + 2) % 3;
            end
        end else if (b[4]) begin
            m_locked = 1'b0;
        end
        exp_q.push_back({st, m_locked, 2'(m_cursor), 2'(m_val[2]), 2'(m_val[1]), 2'(m_val[0])});
        {btn_enter, btn_right, btn_left, btn_down, btn_up} = b;
        @(negedge clk_25MHz);
        {btn_enter, btn_right, btn_left, btn_down, btn_up} = 5'b0;
    endtask

    // Driver: present one coordinate and queue its expected pixel.
    task automatic drive_point(input pt_t p);
        h_cnt     = 9'(p.h);
        v_cnt     = 9'(p.v);
        label_bit = p.lb;
        arrow_bit = p.ab;
        pix_q.push_back(p.px);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk_25MHz);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        h_cnt = 9'd142;
        v_cnt = 9'd139;
        rst   = 1'b1;
        repeat (3) @(negedge clk_25MHz);
        n_total++;
        if (label_addr !== 17'd0) $display("FAIL reset_label_addr got=%0d want=0", label_addr);
        else n_pass++;
        h_cnt = 9'd0;
        v_cnt = 9'd0;
        rst   = 1'b0;
        model_reset();
        repeat (10) @(negedge clk_25MHz);
        n_total++;
        if (cursor !== 2'd0) $display("FAIL reset_cursor got=%0d want=0", cursor);
        else n_pass++;
        n_total++;
        if (item_val !== 6'd0) $display("FAIL reset_item_val got=%h want=0", item_val);
        else n_pass++;
        n_total++;
        if (start !== 1'b0) $display("FAIL reset_start got=%b want=0", start);
        else n_pass++;
        n_total++;
        if (locked !== 1'b0) $display("FAIL reset_locked got=%b want=0", locked);
        else n_pass++;
        n_total++;
        if (pixel !== 12'h000) $display("FAIL reset_pixel got=%h want=000", pixel);
        else n_pass++;
        n_total++;
        if (dbg_state !== 1'b0) $display("FAIL reset_state got=%b want=0", dbg_state);
        else n_pass++;
    endtask

    task automatic test_cursor();
        logic [4:0] seq[4] = '{5'b00010, 5'b00010, 5'b00010, 5'b00001};
        logic [9:0] exp;
        for (int i = 0; i < 4; i++) begin
            press(seq[i]);
            exp = exp_q.pop_front();
            n_total++;
            if ({start, locked, cursor, item_val} !== exp)
                $display("FAIL cursor_step%0d got=%h want=%h", i, {start, locked, cursor, item_val}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_values();
        logic [4:0] seq[8] = '{5'b00010, 5'b01000, 5'b01000, 5'b01000,
                               5'b01100, 5'b00011, 5'b01010, 5'b00101};
        logic [9:0] exp;
        for (int i = 0; i < 8; i++) begin
            press(seq[i]);
            exp = exp_q.pop_front();
            n_total++;
            if ({start, locked, cursor, item_val} !== exp)
                $display("FAIL values_step%0d got=%h want=%h", i, {start, locked, cursor, item_val}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_enter();
        logic [4:0] seq[7] = '{5'b10010, 5'b00000, 5'b00001, 5'b01000,
                               5'b10000, 5'b00000, 5'b00000};
        logic [9:0] exp;
        for (int i = 0; i < 7; i++) begin
            press(seq[i]);
            exp = exp_q.pop_front();
            n_total++;
            if ({start, locked, cursor, item_val} !== exp)
                $display("FAIL enter_step%0d got=%h want=%h", i, {start, locked, cursor, item_val}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [4:0] b;
        logic [9:0] exp;
        for (int i = 0; i < 60; i++) begin
            b = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) b[4] = 1'b0;
            press(b);
            exp = exp_q.pop_front();
            n_total++;
            if ({start, locked, cursor, item_val} !== exp)
                $display("FAIL random_%0d btn=%b got=%h want=%h", i, b, {start, locked, cursor, item_val}, exp);
            else n_pass++;
        end
    endtask

    // Cursor 0, all values 0, MENU, arrows visible (blink counter just reset).
    task automatic test_render_basic();
        pt_t pts[15] = '{
            '{133, 141, 1'b0, 1'b1, 17'd0,    5'd0,  12'hFF0},
            '{183, 141, 1'b0, 1'b1, 17'd0,    5'd3,  12'hFF0},
            '{186, 146, 1'b0, 1'b1, 17'd0,    5'd20, 12'hFF0},
            '{136, 146, 1'b0, 1'b1, 17'd0,    5'd23, 12'hFF0},
            '{137, 141, 1'b0, 1'b1, 17'd0,    5'd0,  12'h000},
            '{134, 162, 1'b0, 1'b1, 17'd0,    5'd1,  12'h000},
            '{141, 138, 1'b1, 1'b0, 17'd0,    5'd0,  12'hFF0},
            '{142, 139, 1'b1, 1'b0, 17'd39,   5'd0,  12'hFF0},
            '{178, 149, 1'b1, 1'b0, 17'd455,  5'd0,  12'hFF0},
            '{179, 138, 1'b1, 1'b0, 17'd0,    5'd0,  12'h000},
            '{141, 150, 1'b1, 1'b0, 17'd0,    5'd0,  12'h000},
            '{141, 159, 1'b1, 1'b0, 17'd1368, 5'd0,  12'hFFF},
            '{160, 180, 1'b1, 1'b0, 17'd2755, 5'd0,  12'hFFF},
            '{141, 138, 1'b0, 1'b1, 17'd0,    5'd0,  12'h000},
            '{140, 138, 1'b1, 1'b0, 17'd0,    5'd0,  12'h000}
        };
        logic [11:0] exp;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive_point(pts[i]);
            #1;
            n_total++;
            if (label_addr !== pts[i].la || arrow_addr !== pts[i].aa)
                $display("FAIL basic_addr%0d got=%0d/%0d want=%0d/%0d", i, label_addr, arrow_addr, pts[i].la, pts[i].aa);
            else n_pass++;
            repeat (2) @(negedge clk_25MHz);
            exp = pix_q.pop_front();
            n_total++;
            if (pixel !== exp) $display("FAIL basic_pixel%0d got=%h want=%h", i, pixel, exp);
            else n_pass++;
        end
    endtask

    // Value and cursor changes show up in addressing and colour.
    task automatic test_render_edit();
        pt_t pts[4] = '{
            '{142, 139, 1'b1, 1'b0, 17'd495,  5'd0, 12'hFF0},
            '{141, 138, 1'b1, 1'b0, 17'd456,  5'd0, 12'hFFF},
            '{141, 159, 1'b1, 1'b0, 17'd1368, 5'd0, 12'hFF0},
            '{134, 162, 1'b0, 1'b1, 17'd0,    5'd1, 12'hFF0}
        };
        logic [9:0]  exp;
        logic [11:0] pexp;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) press(5'b01000);
            if (i == 1) press(5'b00010);
            if (i <= 1) begin
                exp = exp_q.pop_front();
                n_total++;
                if ({start, locked, cursor, item_val} !== exp)
                    $display("FAIL edit_state%0d got=%h want=%h", i, {start, locked, cursor, item_val}, exp);
                else n_pass++;
            end
            if (i == 1) begin
                n_total++;
                if (dbg_blink !== '0) $display("FAIL edit_blink_clear got=%0d want=0", dbg_blink);
                else n_pass++;
            end
            drive_point(pts[i]);
            #1;
            n_total++;
            if (label_addr !== pts[i].la || arrow_addr !== pts[i].aa)
                $display("FAIL edit_addr%0d got=%0d/%0d want=%0d/%0d", i, label_addr, arrow_addr, pts[i].la, pts[i].aa);
            else n_pass++;
            repeat (2) @(negedge clk_25MHz);
            pexp = pix_q.pop_front();
            n_total++;
            if (pixel !== pexp) $display("FAIL edit_pixel%0d got=%h want=%h", i, pixel, pexp);
            else n_pass++;
        end
    endtask

    // Blink count is 6 after test_render_edit. 40 idle cycles bring it to 46,
    // where the MSB is set and the arrows are hidden. 20 more cycles wrap it
    // to 4, where the arrows are visible again.
    task automatic test_blink();
        pt_t         p_hide = '{134, 162, 1'b0, 1'b1, 17'd0, 5'd1, 12'h000};
        pt_t         p_show = '{134, 162, 1'b0, 1'b1, 17'd0, 5'd1, 12'hFF0};
        logic [11:0] exp;
        repeat (40) @(negedge clk_25MHz);
        drive_point(p_hide);
        repeat (2) @(negedge clk_25MHz);
        exp = pix_q.pop_front();
        n_total++;
        if (pixel !== exp) $display("FAIL blink_hidden got=%h want=%h", pixel, exp);
        else n_pass++;
        repeat (20) @(negedge clk_25MHz);
        drive_point(p_show);
        repeat (2) @(negedge clk_25MHz);
        exp = pix_q.pop_front();
        n_total++;
        if (pixel !== exp) $display("FAIL blink_wrap_visible got=%h want=%h", pixel, exp);
        else n_pass++;
    endtask

    // Cursor 1, item 0 value 1, then LOCKED.
    task automatic test_lock_render();
`ifdef MENU_LOCK_DIM_EN
        pt_t pts[3] = '{
            '{141, 159, 1'b1, 1'b0, 17'd1368, 5'd0, 12'h770},
            '{141, 138, 1'b1, 1'b0, 17'd456,  5'd0, 12'h777},
            '{134, 162, 1'b0, 1'b1, 17'd0,    5'd1, 12'h000}
        };
`else
        pt_t pts[3] = '{
            '{141, 159, 1'b1, 1'b0, 17'd1368, 5'd0, 12'hFF0},
            '{141, 138, 1'b1, 1'b0, 17'd456,  5'd0, 12'hFFF},
            '{134, 162, 1'b0, 1'b1, 17'd0,    5'd1, 12'h000}
        };
`endif
        logic [9:0]  exp;
        logic [11:0] pexp;
        press(5'b10000);
        exp = exp_q.pop_front();
        n_total++;
        if ({start, locked, cursor, item_val} !== exp)
            $display("FAIL lock_state got=%h want=%h", {start, locked, cursor, item_val}, exp);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive_point(pts[i]);
            #1;
            n_total++;
            if (label_addr !== pts[i].la || arrow_addr !== pts[i].aa)
                $display("FAIL lock_addr%0d got=%0d/%0d want=%0d/%0d", i, label_addr, arrow_addr, pts[i].la, pts[i].aa);
            else n_pass++;
            repeat (2) @(negedge clk_25MHz);
            pexp = pix_q.pop_front();
            n_total++;
            if (pixel !== pexp) $display("FAIL lock_pixel%0d got=%h want=%h", i, pixel, pexp);
            else n_pass++;
        end
    endtask

    // Reset while LOCKED with a non-zero value, cursor 1, on a lit label.
    task automatic test_reset_locked();
        h_cnt     = 9'd141;
        v_cnt     = 9'd138;
        label_bit = 1'b1;
        arrow_bit = 1'b0;
        rst       = 1'b1;
        @(negedge clk_25MHz);
        n_total++;
        if (locked !== 1'b0 || dbg_state !== 1'b0) $display("FAIL rstlk_locked got=%b want=0", locked);
        else n_pass++;
        n_total++;
        if (item_val !== 6'd0) $display("FAIL rstlk_item_val got=%h want=0", item_val);
        else n_pass++;
        n_total++;
        if (cursor !== 2'd0) $display("FAIL rstlk_cursor got=%0d want=0", cursor);
        else n_pass++;
        n_total++;
        if (dbg_blink !== '0) $display("FAIL rstlk_blink got=%0d want=0", dbg_blink);
        else n_pass++;
        n_total++;
        if (start !== 1'b0) $display("FAIL rstlk_start got=%b want=0", start);
        else n_pass++;
        n_total++;
        if (pixel !== 12'h000) $display("FAIL rstlk_pixel0 got=%h want=000", pixel);
        else n_pass++;
        rst = 1'b0;
        model_reset();
        @(negedge clk_25MHz);
        n_total++;
        if (pixel !== 12'h000) $display("FAIL rstlk_pixel1 got=%h want=000", pixel);
        else n_pass++;
        @(negedge clk_25MHz);
        n_total++;
        if (pixel !== 12'hFF0) $display("FAIL rstlk_pixel2 got=%h want=ff0", pixel);
        else n_pass++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        model_reset();
        @(negedge clk_25MHz);
        test_reset();
        test_cursor();
        test_values();
        test_enter();
        test_random();
        test_render_basic();
        test_render_edit();
        test_blink();
        test_lock_render();
        test_reset_locked();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
